fp32_square: RTL and testbench

Multi-cycle single-precision squarer: result = a × a, with IEEE 754 round-to-nearest-even. It sits beside `fp32_sqrt` in the fp32 arithmetic library as its inverse operation. It takes one operand at a time through a valid/ready handshake and computes the 24×24 mantissa product with an iterative shift-add datapath. Results are held until the consumer accepts them.

---
 rtl/fp32_pkg.sv | 9 +
 rtl/fp32_round_pack.sv | 37 +++
 rtl/fp32_square.sv | 98 +++++++++
 tb/tb_fp32_square.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared constants, field widths and FSM state encoding for the fp32 arithmetic blocks
package fp32_pkg;
    localparam int          FP32_EXP_W   = 8;
    localparam int          FP32_FRAC_W  = 23;
    localparam logic [7:0]  FP32_BIAS    = 8'd127;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0001;
    localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_ROUND, S_DONE} state_t;
endpackage

// File: rtl/fp32_round_pack.sv
// fp32_round_pack: RNE rounding, overflow and underflow handling, packing of a positive fp32 word
// Ports: i_exp (signed unbiased-plus-bias exponent), i_mant (24-bit with hidden bit),
//        i_guard, i_sticky -> o_word (packed IEEE 754 single).
// FP32_SQUARE_SUBNORMAL_EN: when defined, exponents <= 0 produce gradual-underflow subnormals;
// otherwise they flush to +0.
module fp32_round_pack
    import fp32_pkg::*;
(
    input  logic signed [9:0]  i_exp,
    input  logic        [23:0] i_mant,
    input  logic               i_guard,
    input  logic               i_sticky,
    output logic        [31:0] o_word
);
    logic        [24:0] w_nrm_sum;
    logic signed [10:0] w_nrm_exp;
    logic        [31:0] w_normal;
    logic        [31:0] w_sub;
    assign w_nrm_sum = {1'b0, i_mant} + {24'b0, i_guard & (i_sticky | i_mant[0])};
    assign w_nrm_exp = {i_exp[9], i_exp} + {10'b0, w_nrm_sum[24]};
    assign w_normal  = (w_nrm_exp >= 11'sd255) ? FP32_POS_INF :
                       {1'b0, w_nrm_exp[7:0], w_nrm_sum[24] ? w_nrm_sum[23:1] : w_nrm_sum[22:0]};
`ifdef FP32_SQUARE_SUBNORMAL_EN
    logic signed [10:0] w_sh;
    logic        [49:0] w_sub_x;
    logic        [23:0] w_sub_sum;
    // the guard bit rides along in the shift so no information is lost before rounding
    assign w_sh      = 11'sd1 - {i_exp[9], i_exp};
    assign w_sub_x   = {i_mant, i_guard, 25'b0} >> w_sh;
    assign w_sub_sum = w_sub_x[49:26] + {23'b0, w_sub_x[25] & (i_sticky | (|w_sub_x[24:0]) | w_sub_x[26])};
    // a carry into bit 23 lands in the exponent field as the smallest normal
    assign w_sub     = (w_sh >= 11'sd25) ? 32'h0 : {8'b0, w_sub_sum};
`else
    assign w_sub     = 32'h0;
`endif
    assign o_word = (i_exp <= 10'sd0) ? w_sub : w_normal;
endmodule

// File: rtl/fp32_square.sv
// fp32_square: multi-cycle IEEE 754 single-precision squarer (a*a, RNE) with valid/ready handshake
// Ports: clk, rst (sync, active-high), in_valid/in_ready/a (operand), out_valid/out_ready/result.
// BITS_PER_CYCLE multiplier bits are retired per MUL cycle (24/BITS_PER_CYCLE MUL cycles).
// FP32_SQUARE_SUBNORMAL_EN (in fp32_round_pack) enables subnormal results on underflow.
module fp32_square
    import fp32_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);
    localparam int         N    = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] LAST = 5'(N - 1);
    state_t             r_state;
    logic        [31:0] r_result;
    logic        [47:0] r_acc;
    logic        [47:0] r_mcand;
    logic        [23:0] r_mplier;
    logic        [4:0]  r_cnt;
    logic signed [9:0]  r_exp;
    logic        [47:0] w_pp;
    logic signed [9:0]  w_exp;
    logic        [23:0] w_mant;
    logic               w_guard;
    logic               w_sticky;
    logic        [31:0] w_word;
    // partial products for the low multiplier bits, multiplicand pre-shifted by earlier cycles
    always_comb begin
        w_pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            w_pp = w_pp + (r_mplier[i] ? (r_mcand << i) : 48'd0);
    end
    // product lies in [1,4): bit 47 selects the normalization shift
    assign w_exp    = r_exp + {9'b0, r_acc[47]};
    assign w_mant   = r_acc[47] ? r_acc[47:24] : r_acc[46:23];
    assign w_guard  = r_acc[47] ? r_acc[23] : r_acc[22];
    assign w_sticky = r_acc[47] ? |r_acc[22:0] : |r_acc[21:0];
    fp32_round_pack u_round_pack (
        .i_exp    (w_exp),
        .i_mant   (w_mant),
        .i_guard  (w_guard),
        .i_sticky (w_sticky),
        .o_word   (w_word)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_exp    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    if (&a[30:23]) begin
                        r_result <= |a[22:0] ? FP32_QNAN : FP32_POS_INF;
                        r_state  <= S_DONE;
                    end else if (a[30:23] == 8'd0) begin
                        r_result <= '0;
                        r_state  <= S_DONE;
                    end else begin
                        r_acc    <= '0;
                        r_mcand  <= {24'b0, 1'b1, a[22:0]};
                        r_mplier <= {1'b1, a[22:0]};
                        r_cnt    <= '0;
                        r_exp    <= {1'b0, a[30:23], 1'b0} - {2'b0, FP32_BIAS};
                        r_state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc    <= r_acc + w_pp;
                    r_mcand  <= r_mcand << BITS_PER_CYCLE;
                    r_mplier <= r_mplier >> BITS_PER_CYCLE;
                    r_cnt    <= r_cnt + 5'd1;
                    r_state  <= (r_cnt == LAST) ? S_ROUND : S_MUL;
                end
                S_ROUND: begin
                    r_result <= w_word;
                    r_state  <= S_DONE;
                end
                default: r_state <= out_ready ? S_IDLE : S_DONE;
            endcase
        end
    end
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
endmodule

// File: tb/tb_fp32_square.sv
// tb_fp32_square: table-driven scoreboard bench for fp32_square at BITS_PER_CYCLE = 1, 4 and 24
module tb_fp32_square;
    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [31:0] a [3];
    logic [31:0] result [3];
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        fp32_square #(.BITS_PER_CYCLE(g == 0 ? 1 : g == 1 ? 4 : 24)) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .a         (a[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .result    (result[g])
        );
    end
    typedef struct {
        logic [31:0] op;
        logic [31:0] res;
        bit          special;
    } vec_t;
    vec_t        vecs [$];
    logic [31:0] sb [$];
    int          n_vec = 0;
    int          n_err = 0;
    function automatic int n_of(input int d);
        return d == 0 ? 24 : d == 1 ? 6 : 1;
    endfunction
    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s bpc_idx=%0d: got %h expected %h", nm, d, act, exp);
        end
    endtask
    task automatic wait_out(input int d, output int cyc);
        cyc = 1;
        while (!out_valid[d] && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask
    task automatic add(input logic [31:0] op, input logic [31:0] res, input bit sp);
        vec_t v;
        v.op = op;
        v.res = res;
        v.special = sp;
        vecs.push_back(v);
    endtask
    task automatic accept(input int d, input logic [31:0] op);
        a[d] = op;
        in_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        a[d] = 32'hDEAD_BEEF;
    endtask
    task automatic apply(input int d, input logic [31:0] op, input logic [31:0] want, input bit sp);
        int cyc;
        logic [31:0] exp_r;
        chk("in_ready_idle", d, {31'b0, in_ready[d]}, 32'd1);
        sb.push_back(want);
        n_vec++;
        accept(d, op);
        wait_out(d, cyc);
        chk("latency", d, 32'(cyc), 32'(sp ? 1 : n_of(d) + 2));
        exp_r = sb.pop_front();
        chk("result", d, result[d], exp_r);
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
        chk("idle_after_done", d, {30'b0, in_ready[d], out_valid[d]}, 32'b10);
    endtask
    initial begin
        int cyc;
        logic [31:0] held;
        rst = '1;
        in_valid = '0;
        out_ready = '0;
        for (int d = 0; d < 3; d++) a[d] = '0;
        add(32'h4040_0000, 32'h4110_0000, 0);
        add(32'hC000_0000, 32'h4080_0000, 0);
        add(32'h3FC0_0000, 32'h4010_0000, 0);
        add(32'h3F80_0001, 32'h3F80_0002, 0);
        add(32'h3FB5_04F3, 32'h3FFF_FFFF, 0);
        add(32'h3FB5_04F4, 32'h4000_0001, 0);
        add(32'h3FFF_FFFF, 32'h407F_FFFE, 0);
        add(32'h5F7F_FFFF, 32'h7F7F_FFFE, 0);
        add(32'h5F80_0000, 32'h7F80_0000, 0);
`ifdef FP32_SQUARE_SUBNORMAL_EN
        add(32'h1F80_0000, 32'h0020_0000, 0);
        add(32'h1FFF_FFFF, 32'h007F_FFFF, 0);
`else
        add(32'h1F80_0000, 32'h0000_0000, 0);
        add(32'h1FFF_FFFF, 32'h0000_0000, 0);
`endif
        add(32'h7FC1_2345, 32'h7FC0_0001, 1);
        add(32'hFF80_0000, 32'h7F80_0000, 1);
        add(32'h8000_0000, 32'h0000_0000, 1);
        add(32'h0000_0001, 32'h0000_0000, 1);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            chk("reset_state", d, {29'b0, in_ready[d], out_valid[d], |result[d]}, 32'b100);
        rst = '0;
        for (int d = 0; d < 3; d++) begin
            foreach (vecs[i]) apply(d, vecs[i].op, vecs[i].res, vecs[i].special);
            sb.push_back(32'h4110_0000);
            n_vec++;
            accept(d, 32'h4040_0000);
            wait_out(d, cyc);
            chk("bp_latency", d, 32'(cyc), 32'(n_of(d) + 2));
            held = sb.pop_front();
            for (int k = 0; k < 10; k++) begin
                if (k == 4) begin
                    a[d] = 32'h4000_0000;
                    in_valid[d] = 1'b1;
                end
                @(posedge clk);
                #1;
                in_valid[d] = 1'b0;
                chk("bp_result_held", d, result[d], held);
                chk("bp_flags", d, {30'b0, in_ready[d], out_valid[d]}, 32'b01);
            end
            out_ready[d] = 1'b1;
            @(posedge clk);
            #1;
            out_ready[d] = 1'b0;
            chk("bp_release", d, {30'b0, in_ready[d], out_valid[d]}, 32'b10);
            repeat (n_of(d) + 4) @(posedge clk);
            #1;
            chk("bp_pulse_ignored", d, {30'b0, in_ready[d], out_valid[d]}, 32'b10);
            n_vec++;
            accept(d, 32'h4040_0000);
            repeat (n_of(d) > 4 ? 4 : n_of(d) - 1) @(posedge clk);
            #1;
            rst[d] = 1'b1;
            @(posedge clk);
            #1;
            rst[d] = 1'b0;
            chk("rst_mid_mul", d, {29'b0, in_ready[d], out_valid[d], |result[d]}, 32'b100);
            apply(d, 32'h4040_0000, 32'h4110_0000, 0);
            n_vec++;
            rst[d] = 1'b1;
            accept(d, 32'h4040_0000);
            rst[d] = 1'b0;
            chk("rst_beats_valid", d, {30'b0, in_ready[d], out_valid[d]}, 32'b10);
            repeat (n_of(d) + 3) @(posedge clk);
            #1;
            chk("rst_dropped_op", d, {30'b0, in_ready[d], out_valid[d]}, 32'b10);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
